// File: rtl/clkmon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clkmon_pkg
// Purpose  : Shared types, constants and helpers for the clk_monitor block.
// Revision : 1.0 - initial release
// ============================================================================
package clkmon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam int c_LOCK_W = 4;

    // Unsigned distance, larger minus smaller, so it never wraps.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkmon_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : clkmon_edge_det
// Purpose  : Samples the monitored clock and produces level, rise and fall.
//            CLKMON_SYNC_EN inserts a 2-flop synchronizer ahead of detection.
// Revision : 1.0 - initial release
// ============================================================================
module clkmon_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic r_s_d;

`ifdef CLKMON_SYNC_EN
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= clk_in;
            r_sync <= r_meta;
        end
    end

    assign s = r_sync;
`else
    // Monitored clock is already synchronous to clk.
    assign s = clk_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= s;
        end
    end

    assign rise = s & ~r_s_d;
    assign fall = ~s & r_s_d;

endmodule
`default_nettype wire

// File: rtl/clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clk_monitor
// Purpose  : Measures high/low/period of a slow clock, flags mismatch and
//            stuck, declares lock. CLKMON_SYNC_EN adds an input synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
module clk_monitor
    import clkmon_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int EXP_HIGH = 3,
    parameter int EXP_LOW  = 3,
    parameter int TOL      = 0,
    parameter int LOCK_N   = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             en,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             mismatch,
    output logic             stuck,
    output logic             lock
);

    localparam logic [CNT_W-1:0]    c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    c_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [c_LOCK_W-1:0] c_LOCK_N  = c_LOCK_W'(LOCK_N);

    logic w_s;
    logic w_rise;
    logic w_fall;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [CNT_W-1:0]    r_hlat;
    logic [CNT_W-1:0]    w_hlat_nxt;
    logic [c_LOCK_W-1:0] r_good;
    logic [c_LOCK_W-1:0] w_good_nxt;
    logic [c_LOCK_W-1:0] w_good_inc;

    logic                r_meas_valid;
    logic                w_meas_valid_nxt;
    logic [CNT_W-1:0]    r_high;
    logic [CNT_W-1:0]    w_high_nxt;
    logic [CNT_W-1:0]    r_low;
    logic [CNT_W-1:0]    w_low_nxt;
    logic [CNT_W:0]      r_period;
    logic [CNT_W:0]      w_period_nxt;
    logic                r_mismatch;
    logic                w_mismatch_nxt;
    logic                r_stuck;
    logic                w_stuck_nxt;
    logic                r_lock;
    logic                w_lock_nxt;

    logic                w_meas_bad;
    logic                w_timeout;

    clkmon_edge_det u_edge_det (
        .clk    (clk),
        .rst    (rst),
        .clk_in (clk_in),
        .s      (w_s),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_good_inc = (r_good >= c_LOCK_N) ? c_LOCK_N : r_good + c_LOCK_W'(1);

    // Only meaningful in LOW on a rise, where r_cnt holds the finished low time.
    assign w_meas_bad = (abs_diff(32'(r_hlat), 32'(EXP_HIGH)) > 32'(TOL)) ||
                        (abs_diff(32'(r_cnt),  32'(EXP_LOW))  > 32'(TOL));

    // A coincident edge always takes priority over the timeout.
    assign w_timeout  = (r_state != IDLE) && !w_rise && !w_fall && (r_cnt >= c_TIMEOUT);

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_hlat_nxt       = r_hlat;
        w_good_nxt       = r_good;
        w_meas_valid_nxt = 1'b0;
        w_high_nxt       = r_high;
        w_low_nxt        = r_low;
        w_period_nxt     = r_period;
        w_mismatch_nxt   = r_mismatch;
        w_stuck_nxt      = r_stuck;
        w_lock_nxt       = r_lock;

        if (!en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_good_nxt  = '0;
            w_lock_nxt  = 1'b0;
            w_stuck_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SYNC;
                    w_cnt_nxt   = '0;
                end
                SYNC: begin
                    if (w_rise) begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = CNT_W'(1);
                    end else if (w_fall) begin
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        w_hlat_nxt  = r_cnt;
                        w_state_nxt = LOW;
                        w_cnt_nxt   = CNT_W'(1);
                    end else if (w_s) begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_state_nxt      = HIGH;
                        w_cnt_nxt        = CNT_W'(1);
                        w_meas_valid_nxt = 1'b1;
                        w_high_nxt       = r_hlat;
                        w_low_nxt        = r_cnt;
                        w_period_nxt     = {1'b0, r_hlat} + {1'b0, r_cnt};
                        w_mismatch_nxt   = w_meas_bad;
                        w_stuck_nxt      = 1'b0;
                        if (w_meas_bad) begin
                            w_good_nxt = '0;
                            w_lock_nxt = 1'b0;
                        end else begin
                            w_good_nxt = w_good_inc;
                            w_lock_nxt = (w_good_inc == c_LOCK_N);
                        end
                    end else if (!w_s) begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase

            if (w_timeout) begin
                w_state_nxt = SYNC;
                w_cnt_nxt   = '0;
                w_stuck_nxt = 1'b1;
                w_good_nxt  = '0;
                w_lock_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_hlat       <= '0;
            r_good       <= '0;
            r_meas_valid <= 1'b0;
            r_high       <= '0;
            r_low        <= '0;
            r_period     <= '0;
            r_mismatch   <= 1'b0;
            r_stuck      <= 1'b0;
            r_lock       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hlat       <= w_hlat_nxt;
            r_good       <= w_good_nxt;
            r_meas_valid <= w_meas_valid_nxt;
            r_high       <= w_high_nxt;
            r_low        <= w_low_nxt;
            r_period     <= w_period_nxt;
            r_mismatch   <= w_mismatch_nxt;
            r_stuck      <= w_stuck_nxt;
            r_lock       <= w_lock_nxt;
        end
    end

    assign meas_valid = r_meas_valid;
    assign high_cnt   = r_high;
    assign low_cnt    = r_low;
    assign period     = r_period;
    assign mismatch   = r_mismatch;
    assign stuck      = r_stuck;
    assign lock       = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_monitor
// Purpose  : Self-checking bench for clk_monitor (TOL=0 and TOL=1 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_monitor;

`ifdef CLKMON_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_in;
    logic       en;
    logic       meas_valid, mismatch, stuck, lock;
    logic [7:0] high_cnt, low_cnt;
    logic [8:0] period;
    logic       meas_valid_t, mismatch_t, stuck_t, lock_t;
    logic [7:0] high_cnt_t, low_cnt_t;
    logic [8:0] period_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    clk_monitor dut (
        .clk(clk), .rst(rst), .clk_in(clk_in), .en(en),
        .meas_valid(meas_valid), .high_cnt(high_cnt), .low_cnt(low_cnt),
        .period(period), .mismatch(mismatch), .stuck(stuck), .lock(lock)
    );

    clk_monitor #(.TOL(1)) dut_t (
        .clk(clk), .rst(rst), .clk_in(clk_in), .en(en),
        .meas_valid(meas_valid_t), .high_cnt(high_cnt_t), .low_cnt(low_cnt_t),
        .period(period_t), .mismatch(mismatch_t), .stuck(stuck_t), .lock(lock_t)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [8:0] per;
        logic       mm;
        logic       lk;
        logic       st;
        logic       mm_t;
        logic       lk_t;
    } meas_t;

    typedef struct {
        int   h;
        int   l;
        logic mm;
        logic lk;
        logic mm_t;
        logic lk_t;
    } vec_t;

    meas_t mq[$];
    vec_t  vt[13];

    always @(negedge clk) begin
        if (meas_valid) begin
            meas_t m;
            m.cyc  = cyc;
            m.hi   = high_cnt;
            m.lo   = low_cnt;
            m.per  = period;
            m.mm   = mismatch;
            m.lk   = lock;
            m.st   = stuck;
            m.mm_t = mismatch_t;
            m.lk_t = lock_t;
            mq.push_back(m);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int h, input int l);
        clk_in = 1'b1;
        repeat (h) @(negedge clk);
        clk_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic check_meas(input string tag, input int exp_cyc, input int h, input int l,
                              input logic mm, input logic lk, input logic st, output meas_t mo);
        int n = 0;
        while (mq.size() == 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (mq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got 0 measurements, expected 1", tag);
            mo = '{default: 'x};
            return;
        end
        mo = mq.pop_front();
        chk($sformatf("%s_cyc", tag),      mo.cyc, exp_cyc);
        chk($sformatf("%s_high", tag),     mo.hi,  h);
        chk($sformatf("%s_low", tag),      mo.lo,  l);
        chk($sformatf("%s_period", tag),   mo.per, h + l);
        chk($sformatf("%s_mismatch", tag), mo.mm,  mm);
        chk($sformatf("%s_lock", tag),     mo.lk,  lk);
        chk($sformatf("%s_stuck", tag),    mo.st,  st);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        meas_t m;
        int    t0, acc, t_hold, t_r, t_s, t_e;

        vt[0]  = '{3, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{3, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{3, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{3, 3, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{4, 2, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{3, 3, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{2, 5, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{3, 4, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1, 1, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{3, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[10] = '{3, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[11] = '{3, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[12] = '{3, 3, 1'b0, 1'b1, 1'b0, 1'b1};

        rst    = 1'b1;
        en     = 1'b0;
        clk_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_meas_valid", meas_valid, 0);
        chk("rst_high_cnt",   high_cnt,   0);
        chk("rst_low_cnt",    low_cnt,    0);
        chk("rst_period",     period,     0);
        chk("rst_mismatch",   mismatch,   0);
        chk("rst_stuck",      stuck,      0);
        chk("rst_lock",       lock,       0);

        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);

        // Table: each period is reported on the rise that starts the next one.
        t0 = cyc;
        for (int i = 0; i < 13; i++) drive(vt[i].h, vt[i].l);
        clk_in = 1'b1;
        t_hold = cyc;
        acc = 0;
        for (int i = 0; i < 13; i++) begin
            acc += vt[i].h + vt[i].l;
            check_meas($sformatf("v%0d", i), t0 + 1 + acc + LAT, vt[i].h, vt[i].l,
                       vt[i].mm, vt[i].lk, 1'b0, m);
            chk($sformatf("v%0d_mismatch_tol1", i), m.mm_t, vt[i].mm_t);
            chk($sformatf("v%0d_lock_tol1", i),     m.lk_t, vt[i].lk_t);
        end

        // Stuck high: the rise is seen on posedge t_hold+1+LAT, stuck 255 edges later.
        while (cyc < t_hold + LAT + 255) @(negedge clk);
        chk("stuck_before_timeout", stuck, 0);
        chk("lock_before_timeout",  lock,  1);
        @(negedge clk);
        chk("stuck_at_timeout",     stuck, 1);
        chk("lock_at_timeout",      lock,  0);
        while (cyc < t_hold + 300) @(negedge clk);

        mq.delete();
        clk_in = 1'b0;
        repeat (3) @(negedge clk);
        drive(3, 3);
        chk("stuck_sticky", stuck, 1);
        clk_in = 1'b1;
        t_r = cyc;
        check_meas("recover", t_r + 1 + LAT, 3, 3, 1'b0, 1'b0, 1'b0, m);

        // Reset while in HIGH.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_meas_valid", meas_valid, 0);
        chk("midrst_high_cnt",   high_cnt,   0);
        chk("midrst_low_cnt",    low_cnt,    0);
        chk("midrst_period",     period,     0);
        chk("midrst_mismatch",   mismatch,   0);
        chk("midrst_stuck",      stuck,      0);
        chk("midrst_lock",       lock,       0);
        @(negedge clk);
        clk_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        mq.delete();
        t_s = cyc;
        repeat (5) drive(3, 3);

        // Disable in the middle of a low phase.
        clk_in = 1'b1;
        repeat (3) @(negedge clk);
        clk_in = 1'b0;
        repeat (2 + LAT) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        chk("dis_lock",       lock,       0);
        chk("dis_stuck",      stuck,      0);
        chk("dis_high_cnt",   high_cnt,   3);
        chk("dis_low_cnt",    low_cnt,    3);
        chk("dis_period",     period,     6);
        chk("dis_mismatch",   mismatch,   0);
        chk("dis_meas_valid", meas_valid, 0);
        for (int k = 0; k < 5; k++) begin
            check_meas($sformatf("postrst_m%0d", k), t_s + 1 + 6 * (k + 1) + LAT, 3, 3,
                       1'b0, (k >= 3) ? 1'b1 : 1'b0, 1'b0, m);
        end
        chk("dis_no_extra_meas", mq.size(), 0);

        en = 1'b1;
        repeat (3) @(negedge clk);
        t_e = cyc;
        drive(3, 3);
        clk_in = 1'b1;
        check_meas("reen", t_e + 7 + LAT, 3, 3, 1'b0, 1'b0, 1'b0, m);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
